// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: CDB packet type and default CDB sizing shared by
// the arbiter, the ROB and the reservation stations.
package cdb_arbiter_pkg;

   localparam int DEF_NUM_FU = 4;
   localparam int DEF_CDB_SZ = 2;

   typedef struct packed {
      logic [31:0] alu_result;
      logic [4:0]  rob_tag;
      logic [5:0]  dest_prn;
      logic        take_branch;
   } FU_PACKET;

endpackage

// File: rtl/cdb_arbiter_picker.sv
// rr_picker: round-robin pick of up to K requesters starting at ptr,
// with a one-hot select per output slot in scan order.
module rr_picker #(
   parameter int N = 4,
   parameter int K = 2,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]        req,
   input  logic [PW-1:0]       ptr,
   output logic [N-1:0]        grant,
   output logic [K-1:0][N-1:0] sel
);

   logic [N-1:0]        rot_req;
   logic [N-1:0]        rot_gnt;
   logic [K-1:0][N-1:0] rot_sel;

   function automatic logic [PW-1:0] rot_idx(input logic [PW-1:0] p,
                                             input int j);
      int s;
      s = (int'(p) + j) % N;
      return PW'(s);
   endfunction

   always_comb begin
      int taken;
      rot_req = '0;
      rot_gnt = '0;
      rot_sel = '0;
      grant   = '0;
      sel     = '0;
      taken   = 0;
      for (int j = 0; j < N; j++) begin
         rot_req[j] = req[rot_idx(ptr, j)];
      end
      // fixed priority in rotated space: position 0 is the ptr index
      for (int j = 0; j < N; j++) begin
         if (rot_req[j] && taken < K) begin
            rot_gnt[j] = 1'b1;
            for (int k = 0; k < K; k++) begin
               if (k == taken) rot_sel[k][j] = 1'b1;
            end
            taken = taken + 1;
         end
      end
      for (int j = 0; j < N; j++) begin
         grant[rot_idx(ptr, j)] = rot_gnt[j];
         for (int k = 0; k < K; k++) begin
            sel[k][rot_idx(ptr, j)] = rot_sel[k][j];
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants up to CDB_SZ FU results per cycle onto the
// registered CDB, round-robin, stalling the FUs that lose.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_FU = DEF_NUM_FU,
   parameter int CDB_SZ = DEF_CDB_SZ,
   localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [NUM_FU-1:0]        fu_valid,
   input  FU_PACKET [NUM_FU-1:0]    fu_packs,
   output logic [NUM_FU-1:0]        fu_stall,
   output logic [CDB_SZ-1:0]        cdb_valid,
   output FU_PACKET [CDB_SZ-1:0]    cdb_packs
);

   logic [NUM_FU-1:0]             req;
   logic [NUM_FU-1:0]             grant;
   logic [CDB_SZ-1:0][NUM_FU-1:0] sel;

   logic [PW-1:0]                 rr_ptr_q, rr_ptr_d;
   logic [CDB_SZ-1:0]             cdb_valid_q, cdb_valid_d;
   FU_PACKET [CDB_SZ-1:0]         cdb_packs_q, cdb_packs_d;

   // squashed FUs neither win nor stall
   always_comb begin
      req = fu_valid;
      if (reset || flush) req = '0;
   end

   rr_picker #(
      .N (NUM_FU),
      .K (CDB_SZ)
   ) u_picker (
      .req   (req),
      .ptr   (rr_ptr_q),
      .grant (grant),
      .sel   (sel)
   );

   always_comb begin
      fu_stall = req & ~grant;
   end

   always_comb begin
      cdb_valid_d = '0;
      cdb_packs_d = '0;
      for (int k = 0; k < CDB_SZ; k++) begin
         cdb_valid_d[k] = |sel[k];
         for (int i = 0; i < NUM_FU; i++) begin
            if (sel[k][i]) cdb_packs_d[k] = fu_packs[i];
         end
      end
   end

   // slots fill in scan order, so the highest filled slot is the last grant
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      for (int k = 0; k < CDB_SZ; k++) begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (sel[k][i]) rr_ptr_d = PW'((i + 1) % NUM_FU);
         end
      end
      if (flush) rr_ptr_d = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr_q    <= '0;
         cdb_valid_q <= '0;
         cdb_packs_q <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_packs_q <= cdb_packs_d;
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_packs = cdb_packs_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table vectors, hand sequences and random traffic
// checked against a queue-based round-robin reference model.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int NF = 4;
   localparam int CS = 2;

   logic              clock = 1'b0;
   logic              reset;
   logic              flush;
   logic [NF-1:0]     fu_valid;
   FU_PACKET [NF-1:0] fu_packs;
   logic [NF-1:0]     fu_stall;
   logic [CS-1:0]     cdb_valid;
   FU_PACKET [CS-1:0] cdb_packs;

   cdb_arbiter #(.NUM_FU(NF), .CDB_SZ(CS)) dut (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .fu_valid  (fu_valid),
      .fu_packs  (fu_packs),
      .fu_stall  (fu_stall),
      .cdb_valid (cdb_valid),
      .cdb_packs (cdb_packs)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   int            m_ptr;
   int            gl[$];
   logic [NF-1:0] exp_stall;
   logic [CS-1:0] exp_cv;
   FU_PACKET      exp_cp[CS];
   logic [NF-1:0] obs_stall;
   int            waitc[NF];

   typedef struct {
      logic       fl;
      logic [3:0] v;
      logic [3:0] st;
      logic [1:0] cv;
      int         s0;
      int         s1;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic FU_PACKET pk_of(input int i);
      FU_PACKET p;
      p.alu_result  = (i == 2) ? 32'hCAFE : 32'(32'h1000 + i);
      p.rob_tag     = 5'(i + 1);
      p.dest_prn    = 6'(i + 8);
      p.take_branch = 1'(i & 1);
      return p;
   endfunction

   function automatic FU_PACKET pk_or_zero(input int i);
      FU_PACKET z;
      z = '0;
      if (i < 0) return z;
      return pk_of(i);
   endfunction

   // one cycle: model the grant from the rules, compare stall now and CDB next cycle
   task automatic tick();
      gl.delete();
      if (!flush) begin
         for (int s = 0; s < NF; s++) begin
            int i;
            i = (m_ptr + s) % NF;
            if (fu_valid[i] && gl.size() < CS) gl.push_back(i);
         end
      end
      exp_stall = flush ? '0 : fu_valid;
      foreach (gl[n]) exp_stall[gl[n]] = 1'b0;
      for (int k = 0; k < CS; k++) begin
         exp_cv[k] = (k < gl.size());
         exp_cp[k] = (k < gl.size()) ? fu_packs[gl[k]] : '0;
      end
      #1;
      obs_stall = fu_stall;
      chk("stall_model", 64'(obs_stall), 64'(exp_stall));
      @(posedge clock);
      #1;
      chk("cdbv_model", 64'(cdb_valid), 64'(exp_cv));
      for (int k = 0; k < CS; k++) begin
         chk("cdbp_model", 64'(cdb_packs[k]), 64'(exp_cp[k]));
      end
      if (flush) m_ptr = 0;
      else if (gl.size() > 0) m_ptr = (gl[gl.size() - 1] + 1) % NF;
   endtask

   task automatic load_fixed();
      for (int i = 0; i < NF; i++) fu_packs[i] = pk_of(i);
   endtask

   initial begin
      int hits2;
      int hits_after;

      tbl[0]  = '{1'b0, 4'b1111, 4'b1100, 2'b11,  0,  1};
      tbl[1]  = '{1'b0, 4'b1111, 4'b0011, 2'b11,  2,  3};
      tbl[2]  = '{1'b0, 4'b1111, 4'b1100, 2'b11,  0,  1};
      tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 2'b00, -1, -1};
      tbl[4]  = '{1'b0, 4'b1001, 4'b0000, 2'b11,  3,  0};
      tbl[5]  = '{1'b0, 4'b0100, 4'b0000, 2'b01,  2, -1};
      tbl[6]  = '{1'b0, 4'b1001, 4'b0000, 2'b11,  3,  0};
      tbl[7]  = '{1'b1, 4'b1111, 4'b0000, 2'b00, -1, -1};
      tbl[8]  = '{1'b0, 4'b1111, 4'b1100, 2'b11,  0,  1};
      tbl[9]  = '{1'b0, 4'b0111, 4'b0010, 2'b11,  2,  0};
      tbl[10] = '{1'b0, 4'b1110, 4'b1000, 2'b11,  1,  2};
      tbl[11] = '{1'b0, 4'b0010, 4'b0000, 2'b01,  1, -1};

      reset    = 1'b1;
      flush    = 1'b0;
      fu_valid = 4'b1111;
      load_fixed();
      m_ptr    = 0;
      repeat (2) begin
         #1;
         chk("rst_stall", 64'(fu_stall), 64'(0));
         @(posedge clock);
         #1;
         chk("rst_cdbv", 64'(cdb_valid), 64'(0));
      end
      reset = 1'b0;

      for (int n = 0; n < 12; n++) begin
         flush    = tbl[n].fl;
         fu_valid = tbl[n].v;
         load_fixed();
         tick();
         chk("tbl_stall", 64'(obs_stall), 64'(tbl[n].st));
         chk("tbl_cdbv", 64'(cdb_valid), 64'(tbl[n].cv));
         chk("tbl_slot0", 64'(cdb_packs[0]), 64'(pk_or_zero(tbl[n].s0)));
         chk("tbl_slot1", 64'(cdb_packs[1]), 64'(pk_or_zero(tbl[n].s1)));
      end

      // hold-and-retry: FU2 loses first, keeps its packet, wins once
      flush    = 1'b1;
      fu_valid = '0;
      tick();
      flush      = 1'b0;
      fu_valid   = 4'b1111;
      load_fixed();
      fu_packs[2].alu_result = 32'h1234;
      hits2      = 0;
      hits_after = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         for (int k = 0; k < CS; k++) begin
            if (cdb_valid[k] && cdb_packs[k].alu_result == 32'h1234) begin
               if (c < 2) hits2++;
               else hits_after++;
            end
         end
         if (c == 0) begin
            fu_packs[0].alu_result = 32'h2000;
            fu_packs[1].alu_result = 32'h2001;
         end else begin
            fu_valid = '0;
         end
      end
      chk("retry_once", 64'(hits2), 64'(1));
      chk("retry_nodup", 64'(hits_after), 64'(0));

      // random traffic; losers hold their packet as FUs must
      for (int i = 0; i < NF; i++) waitc[i] = 0;
      fu_valid = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NF; i++) begin
            if (!exp_stall[i] || flush) begin
               fu_valid[i]             = 1'($urandom_range(0, 2) != 0);
               fu_packs[i].alu_result  = $urandom;
               fu_packs[i].rob_tag     = 5'($urandom);
               fu_packs[i].dest_prn    = 6'($urandom);
               fu_packs[i].take_branch = 1'($urandom);
            end
         end
         flush = ($urandom_range(0, 15) == 0);
         tick();
         for (int i = 0; i < NF; i++) begin
            if (flush) waitc[i] = 0;
            else if (fu_valid[i] && !obs_stall[i]) begin
               chk("starve", 64'(waitc[i]), 64'(waitc[i] <= 1 ? waitc[i] : 1));
               waitc[i] = 0;
            end else if (obs_stall[i]) waitc[i]++;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
